// File: rtl/spi_reg_decoder_pkg.sv
// Shared definitions for the SPI register decoder: register map, FSM state
// encoding and the default header/reset constants.
package spi_reg_decoder_pkg;

    localparam int NUM_REGS_DEF = 6;
    localparam int ADDR_W       = 3;

    localparam int REG_RED   = 0;
    localparam int REG_GREEN = 1;
    localparam int REG_BLUE  = 2;
    localparam int REG_WHITE = 3;
    localparam int REG_LUM   = 4;
    localparam int REG_CTRL  = 5;

    localparam logic [3:0] SYNC_NIBBLE_DEF = 4'hA;
    localparam logic [7:0] LUM_RST_DEF     = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_DATA = 2'd2,
        ST_DROP = 2'd3
    } state_e;

    // Reset value of a register slot; only lum powers up non-zero.
    function automatic logic [7:0] reg_rst_val(input int idx, input logic [7:0] lum_rst);
        return (idx == REG_LUM) ? lum_rst : 8'h00;
    endfunction

endpackage

// File: rtl/spi_reg_bank.sv
// Shadow and committed register storage. Writes land in the shadows; commit
// copies shadows (including a same-cycle write) to the outputs, restore undoes them.
module spi_reg_bank
    import spi_reg_decoder_pkg::*;
#(
    parameter int         NUM_REGS = NUM_REGS_DEF,
    parameter logic [7:0] LUM_RST  = LUM_RST_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     en,
    input  logic                     we,
    input  logic [ADDR_W-1:0]        addr,
    input  logic [7:0]               wdata,
    input  logic                     commit,
    input  logic                     restore,
    output logic [NUM_REGS-1:0][7:0] regs_o
);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
            localparam logic [7:0] RST_VAL = reg_rst_val(gi, LUM_RST);

            logic [7:0] shadow_q;
            logic [7:0] shadow_d;
            logic [7:0] committed_q;
            logic [7:0] committed_d;

            always_comb begin
                shadow_d = shadow_q;
                if (restore) begin
                    shadow_d = committed_q;
                end else if (we && (addr == ADDR_W'(gi))) begin
                    shadow_d = wdata;
                end
                committed_d = commit ? shadow_d : committed_q;
            end

            always_ff @(posedge clk) begin
                if (en) begin
                    if (!reset) begin
                        shadow_q    <= RST_VAL;
                        committed_q <= RST_VAL;
                    end else begin
                        shadow_q    <= shadow_d;
                        committed_q <= committed_d;
                    end
                end
            end

            assign regs_o[gi] = committed_q;
        end
    endgenerate

endmodule

// File: rtl/spi_reg_decoder.sv
// Frame parser between the SPI byte receiver and the PWM/mixer stages:
// header check, auto-incrementing shadow writes, atomic commit at frame end.
module spi_reg_decoder
    import spi_reg_decoder_pkg::*;
#(
    parameter int         NUM_REGS    = NUM_REGS_DEF,
    parameter logic [3:0] SYNC_NIBBLE = SYNC_NIBBLE_DEF,
    parameter logic [7:0] LUM_RST     = LUM_RST_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clk_half,
    input  logic       cs,
    input  logic       rdy,
    input  logic [7:0] data,
    output logic [7:0] red,
    output logic [7:0] green,
    output logic [7:0] blue,
    output logic [7:0] white,
    output logic [7:0] lum,
    output logic [7:0] ctrl,
    output logic       upd,
    output logic       err
);

    localparam int CNT_W = $clog2(NUM_REGS + 1);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                cs_q, cs_d;
    logic                upd_q, upd_d;
    logic                err_q, err_d;

    logic                en;
    logic                frame_end;
    logic                hdr_ok;
    logic                we;
    logic                commit;
    logic                restore;
    logic                hdr_unused;
    logic [NUM_REGS-1:0][7:0] regs;

    assign en         = ~clk_half;
    assign frame_end  = ~cs_q & cs;
    assign hdr_ok     = (data[7:4] == SYNC_NIBBLE) &&
                        ({1'b0, data[ADDR_W-1:0]} < (ADDR_W+1)'(NUM_REGS));
    // Header bit 3 is reserved.
    assign hdr_unused = data[3];

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        cs_d    = cs;
        upd_d   = 1'b0;
        err_d   = err_q;
        we      = 1'b0;
        commit  = 1'b0;
        restore = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!cs) begin
                    state_d = ST_HDR;
                end
            end
            ST_HDR: begin
                // A header byte coinciding with frame end is simply discarded.
                if (rdy && !frame_end) begin
                    if (hdr_ok) begin
                        ptr_d   = data[ADDR_W-1:0];
                        cnt_d   = '0;
                        state_d = ST_DATA;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_DROP;
                    end
                end
            end
            ST_DATA: begin
                if (rdy) begin
                    if (cnt_q == CNT_W'(NUM_REGS)) begin
                        err_d   = 1'b1;
                        state_d = ST_DROP;
                    end else begin
                        we    = 1'b1;
                        cnt_d = cnt_q + 1'b1;
                        ptr_d = (ptr_q == ADDR_W'(NUM_REGS - 1)) ? '0 : ptr_q + 1'b1;
                    end
                end
            end
            default: begin
            end
        endcase

        // End condition is judged after the same-cycle byte has been applied.
        if (frame_end) begin
            if ((state_d == ST_DATA) && (cnt_d != '0)) begin
                commit = 1'b1;
                upd_d  = 1'b1;
                err_d  = 1'b0;
            end else begin
                restore = 1'b1;
            end
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (en) begin
            if (!reset) begin
                state_q <= ST_IDLE;
                ptr_q   <= '0;
                cnt_q   <= '0;
                cs_q    <= 1'b1;
                upd_q   <= 1'b0;
                err_q   <= 1'b0;
            end else begin
                state_q <= state_d;
                ptr_q   <= ptr_d;
                cnt_q   <= cnt_d;
                cs_q    <= cs_d;
                upd_q   <= upd_d;
                err_q   <= err_d;
            end
        end
    end

    spi_reg_bank #(
        .NUM_REGS (NUM_REGS),
        .LUM_RST  (LUM_RST)
    ) u_bank (
        .clk     (clk),
        .reset   (reset),
        .en      (en),
        .we      (we),
        .addr    (ptr_q),
        .wdata   (data),
        .commit  (commit),
        .restore (restore),
        .regs_o  (regs)
    );

    assign red   = regs[REG_RED];
    assign green = regs[REG_GREEN];
    assign blue  = regs[REG_BLUE];
    assign white = regs[REG_WHITE];
    assign lum   = regs[REG_LUM];
    assign ctrl  = regs[REG_CTRL];
    assign upd   = upd_q;
    assign err   = err_q;

endmodule

// File: tb/tb_spi_reg_decoder.sv
// Self-checking bench: directed frames from the test plan, then random frames,
// compared against a frame-level reference model of the register map.
module tb_spi_reg_decoder;

    typedef logic [7:0] byte_q_t[$];

    logic       clk      = 1'b0;
    logic       clk_half = 1'b0;
    logic       reset    = 1'b0;
    logic       cs       = 1'b1;
    logic       rdy      = 1'b0;
    logic [7:0] data     = 8'h00;
    logic [7:0] red, green, blue, white, lum, ctrl;
    logic       upd, err;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] m_regs [6];
    logic       m_err;

    spi_reg_decoder dut (
        .clk      (clk),
        .reset    (reset),
        .clk_half (clk_half),
        .cs       (cs),
        .rdy      (rdy),
        .data     (data),
        .red      (red),
        .green    (green),
        .blue     (blue),
        .white    (white),
        .lum      (lum),
        .ctrl     (ctrl),
        .upd      (upd),
        .err      (err)
    );

    always #5 clk = ~clk;
    always @(negedge clk) clk_half = ~clk_half;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next enabled clock edge.
    task automatic step();
        do @(posedge clk); while (clk_half != 1'b0);
        #1;
    endtask

    task automatic gap();
        int n;
        n = $urandom_range(0, 2);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic model_reset();
        for (int i = 0; i < 6; i++) m_regs[i] = 8'h00;
        m_regs[4] = 8'hFF;
        m_err = 1'b0;
    endtask

    task automatic check_outputs(input string tag);
        check_val({tag, ".red"},   red,   m_regs[0]);
        check_val({tag, ".green"}, green, m_regs[1]);
        check_val({tag, ".blue"},  blue,  m_regs[2]);
        check_val({tag, ".white"}, white, m_regs[3]);
        check_val({tag, ".lum"},   lum,   m_regs[4]);
        check_val({tag, ".ctrl"},  ctrl,  m_regs[5]);
        check_val({tag, ".err"},   err,   m_err);
    endtask

    // Send one cs-delimited frame; join_end raises cs together with the last byte.
    task automatic run_frame(input string tag, input byte_q_t fb, input bit join_end);
        logic       exp_upd;
        logic [7:0] hdr;
        int         p;
        int         n;

        exp_upd = 1'b0;
        n = fb.size();
        if (n >= 1 && !(join_end && n == 1)) begin
            hdr = fb[0];
            if (hdr[7:4] != 4'hA || hdr[2:0] >= 3'd6) begin
                m_err = 1'b1;
            end else if (n - 1 > 6) begin
                m_err = 1'b1;
            end else if (n > 1) begin
                p = int'(hdr[2:0]);
                for (int i = 1; i < n; i++) begin
                    m_regs[p] = fb[i];
                    p = (p + 1) % 6;
                end
                m_err   = 1'b0;
                exp_upd = 1'b1;
            end
        end

        cs = 1'b0;
        step();
        gap();
        for (int i = 0; i < n; i++) begin
            rdy  = 1'b1;
            data = fb[i];
            if (join_end && i == n - 1) cs = 1'b1;
            step();
            rdy  = 1'b0;
            data = 8'($urandom);
            if (!(join_end && i == n - 1)) begin
                check_val({tag, ".upd_mid"}, upd, 1'b0);
                gap();
            end
        end
        if (!(join_end && n > 0)) begin
            cs = 1'b1;
            step();
        end
        check_val({tag, ".upd"}, upd, exp_upd);
        check_outputs(tag);
        step();
        check_val({tag, ".upd_off"}, upd, 1'b0);
        $display("frame %s: %0d bytes join=%0d upd=%0d err=%0d", tag, n, join_end, upd, err);
        gap();
    endtask

    initial begin
        byte_q_t fb;
        int      nb;

        model_reset();
        reset = 1'b0;
        step();
        step();
        check_val("rst.upd", upd, 1'b0);
        check_outputs("rst");
        reset = 1'b1;
        step();

        run_frame("basic",    '{8'hA0, 8'h11, 8'h22, 8'h33, 8'h44}, 1'b0);
        run_frame("wrap",     '{8'hA4, 8'h80, 8'h05, 8'h77}, 1'b0);
        run_frame("badhdr",   '{8'h50, 8'h12}, 1'b0);
        run_frame("recover",  '{8'hA1, 8'h9A}, 1'b0);
        run_frame("overflow", '{8'hA0, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07}, 1'b0);
        run_frame("restore",  '{8'hA5, 8'h01}, 1'b0);
        run_frame("hdronly",  '{8'hA2}, 1'b0);
        run_frame("joined",   '{8'hA3, 8'h3C}, 1'b0 ? 1'b0 : 1'b1);
        run_frame("full6",    '{8'hA0, 8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hC5, 8'hC6}, 1'b0);
        run_frame("hdrjoin",  '{8'h31}, 1'b1);

        // Reset in the middle of a frame with cs held low.
        cs = 1'b0;
        step();
        rdy = 1'b1; data = 8'hA0; step();
        rdy = 1'b1; data = 8'h55; step();
        rdy = 1'b0;
        reset = 1'b0;
        step();
        model_reset();
        check_val("midrst.upd", upd, 1'b0);
        check_outputs("midrst");
        reset = 1'b1;
        step();
        cs = 1'b1;
        step();
        check_val("midrst.upd_after", upd, 1'b0);
        check_outputs("midrst_after");
        $display("frame midrst: reset during frame, upd=%0d", upd);
        step();

        for (int f = 0; f < 40; f++) begin
            if ($urandom_range(0, 3) == 0) begin
                rdy = 1'b1; data = 8'($urandom); step(); rdy = 1'b0;
            end
            fb = {};
            nb = $urandom_range(0, 8);
            for (int i = 0; i <= nb; i++) begin
                if (i == 0) begin
                    if ($urandom_range(0, 3) != 0)
                        fb.push_back({4'hA, 1'($urandom), 3'($urandom_range(0, 7))});
                    else
                        fb.push_back(8'($urandom));
                end else begin
                    fb.push_back(8'($urandom));
                end
            end
            if ($urandom_range(0, 7) == 0) fb = {};
            run_frame($sformatf("rnd%0d", f), fb, 1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
